// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for MiniMIPS: loadable program store, 6-bit PC sequencer, valid/ready issue port.
// Optional `IFU_ISSUE_COUNT_EN adds a saturating count of completed handshakes on issue_count.
module instr_fetch_unit #(
  parameter int         ADDR_W  = 6,
  parameter int         DEPTH   = 2**ADDR_W,
  parameter int         INSTR_W = 16,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
`ifdef IFU_ISSUE_COUNT_EN
  ,output logic [15:0]       issue_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rd_dat;
  logic               r_rd_ok;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_vld;

  logic w_busy;
  logic w_start_ok;
  logic w_redir;
  logic w_hs;
  logic w_is_halt;
  logic w_fetch_done;

  assign w_busy       = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign w_start_ok   = start && !w_busy;
  assign w_redir      = redirect_en && w_busy;
  assign w_hs         = (r_state == S_ISSUE) && r_instr_vld && instr_ready;
  assign w_is_halt    = (r_rd_dat[INSTR_W-1 -: 4] == HALT_OP);
  assign w_fetch_done = (r_state == S_FETCH) && r_rd_ok && !w_redir;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_redir)      w_state_nxt = S_FETCH;
        else if (r_rd_ok) w_state_nxt = w_is_halt ? S_HALT : S_ISSUE;
      end
      S_ISSUE: if (w_redir || w_hs) w_state_nxt = S_FETCH;
      S_HALT:  if (start) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy   = 1'b0;
    halted = 1'b0;
    case (r_state)
      S_FETCH, S_ISSUE: busy   = 1'b1;
      S_HALT:           halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_start_ok)   w_pc_nxt = '0;
    else if (w_redir) w_pc_nxt = redirect_pc;
    else if (w_hs)    w_pc_nxt = r_pc + ADDR_W'(1);
  end

  // Program store: no reset; the read port looks ahead at the next PC
  always_ff @(posedge clk) begin
    if (load_en && !w_busy) r_mem[load_addr] <= load_data;
    r_rd_dat <= r_mem[w_pc_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= '0;
      r_rd_ok     <= 1'b0;
      r_instr     <= '0;
      r_instr_vld <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      // A load accepted alongside start may hit word 0 at the same edge as the
      // look-ahead read, so the first word after start is always re-read.
      r_rd_ok <= (w_state_nxt == S_FETCH) && !w_start_ok;
      if (w_fetch_done && !w_is_halt) begin
        r_instr     <= r_rd_dat;
        r_instr_vld <= 1'b1;
      end else if (w_hs || w_redir) begin
        r_instr_vld <= 1'b0;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_vld;
  assign pc          = r_pc;

`ifdef IFU_ISSUE_COUNT_EN
  logic [15:0] r_issue_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_issue_cnt <= '0;
    else if (w_start_ok)                   r_issue_cnt <= '0;
    else if (w_hs && r_issue_cnt != '1)    r_issue_cnt <= r_issue_cnt + 16'd1;
  end

  assign issue_count = r_issue_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program run, stall, async reset, redirect, PC wrap, busy loads.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_en;
  logic [5:0]  redirect_pc;
  logic [5:0]  pc;
  logic        busy;
  logic        halted;
`ifdef IFU_ISSUE_COUNT_EN
  logic [15:0] issue_count;
`endif

  int n_vec;
  int n_err;
  bit saw_halt_op;
  bit saw_2222;
  bit saw_7777;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
`ifdef IFU_ISSUE_COUNT_EN
    ,.issue_count(issue_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_valid) begin
      if (instr[15:12] == 4'hF) saw_halt_op = 1'b1;
      if (instr == 16'h2222)    saw_2222    = 1'b1;
      if (instr == 16'h7777)    saw_7777    = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic [15:0] exp_i, input logic [5:0] exp_pc);
    @(negedge clk);
    chk({tag, "_vld"},   32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(instr),       32'(exp_i));
    chk({tag, "_pc"},    32'(pc),          32'(exp_pc));
  endtask

  // Runs the three-word program (0050, 1081, F000) from IDLE/HALT with ready high
  task automatic run_prog1(input string tg);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk({tg, "_lat1_vld"}, 32'(instr_valid), 32'd0);
    chk({tg, "_busy"},     32'(busy),        32'd1);
    tick();
    @(negedge clk);
    chk({tg, "_lat2_vld"}, 32'(instr_valid), 32'd0);
    tick();
    check_issue({tg, "_i0"}, 16'h0050, 6'd0);
    tick();
    @(negedge clk);
    chk({tg, "_gap_vld"}, 32'(instr_valid), 32'd0);
    chk({tg, "_gap_pc"},  32'(pc),          32'd1);
    tick();
    check_issue({tg, "_i1"}, 16'h1081, 6'd1);
    tick();
    tick();
    @(negedge clk);
    chk({tg, "_halted"}, 32'(halted),      32'd1);
    chk({tg, "_busy0"},  32'(busy),        32'd0);
    chk({tg, "_hpc"},    32'(pc),          32'd2);
    chk({tg, "_hvld"},   32'(instr_valid), 32'd0);
`ifdef IFU_ISSUE_COUNT_EN
    chk({tg, "_count"},  32'(issue_count), 32'd2);
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    saw_halt_op = 1'b0; saw_2222 = 1'b0; saw_7777 = 1'b0;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; instr_ready = 1'b0; redirect_en = 1'b0; redirect_pc = '0;

    @(negedge clk);
    chk("rst_pc",     32'(pc),          32'd0);
    chk("rst_instr",  32'(instr),       32'd0);
    chk("rst_vld",    32'(instr_valid), 32'd0);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_halted", 32'(halted),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic program
    load(6'd0, 16'h0050);
    load(6'd1, 16'h1081);
    load(6'd2, 16'hF000);
    run_prog1("t1");

    // Stall in ISSUE
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_issue("t2_first", 16'h0050, 6'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_issue("t2_hold", 16'h0050, 6'd0);
    end
    instr_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_hs_vld", 32'(instr_valid), 32'd0);
    chk("t2_hs_pc",  32'(pc),          32'd1);
    tick();
    check_issue("t2_next", 16'h1081, 6'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t2_halted", 32'(halted), 32'd1);

    // Async reset in the middle of ISSUE
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_issue("t5_pre", 16'h0050, 6'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_vld",    32'(instr_valid), 32'd0);
    chk("t5_busy",   32'(busy),        32'd0);
    chk("t5_pc",     32'(pc),          32'd0);
    chk("t5_instr",  32'(instr),       32'd0);
    chk("t5_halted", 32'(halted),      32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_prog1("t5");

    // Redirect with simultaneous handshake
    load(6'd2, 16'h2222);
    load(6'd5, 16'h5555);
    load(6'd6, 16'hF000);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_issue("t3_i0", 16'h0050, 6'd0);
    tick();
    tick();
    check_issue("t3_i1", 16'h1081, 6'd1);
    redirect_en = 1'b1; redirect_pc = 6'd5;
    tick();
    redirect_en = 1'b0;
    @(negedge clk);
    chk("t3_rd_vld", 32'(instr_valid), 32'd0);
    chk("t3_rd_pc",  32'(pc),          32'd5);
    tick();
    check_issue("t3_i5", 16'h5555, 6'd5);
    tick();
    tick();
    @(negedge clk);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_hpc",    32'(pc),     32'd6);

    // PC wrap 63 -> 0
    load(6'd63, 16'h0011);
    load(6'd0,  16'h0022);
    load(6'd1,  16'hF000);
    start = 1'b1;
    tick();
    start = 1'b0;
    redirect_en = 1'b1; redirect_pc = 6'd63;
    tick();
    redirect_en = 1'b0;
    tick();
    check_issue("t4_i63", 16'h0011, 6'd63);
    tick();
    tick();
    check_issue("t4_i0", 16'h0022, 6'd0);
    tick();
    tick();
    @(negedge clk);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_hpc",    32'(pc),     32'd1);

    // Loads while busy are dropped
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_en = 1'b1; load_addr = 6'd1; load_data = 16'h7777;
    tick();
    tick();
    check_issue("t6_i0", 16'h0022, 6'd0);
    instr_ready = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_hpc",    32'(pc),     32'd1);
`ifdef IFU_ISSUE_COUNT_EN
    chk("t6_count",  32'(issue_count), 32'd1);
`endif

    chk("never_issued_halt_op", 32'(saw_halt_op), 32'd0);
    chk("never_issued_mem2",    32'(saw_2222),    32'd0);
    chk("never_issued_busyld",  32'(saw_7777),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
